perf_monitor: RTL and testbench
===============================

Name: perf_monitor

Overview:
- Parametrised cycle/instruction performance monitor that snoops the CPU's fetched instruction and PC each clock. Counts cycles, NOPs (instr == 0), stalls (PC unchanged), retired non-NOP instructions and NUM_EV generic event lines.
- Supports start/freeze/clear control, an optional fixed sampling window with shadow snapshot, saturating or wrapping counters, and an addressed read port.
- Sits beside the CPU top and is read by the bench or a debug bus.

Parameters:
- NUM_EV, 4: number of generic event inputs (1..12).
- CNT_W, 32: width of every counter.
- PC_W, 32: PC/instruction width.
- WINDOW, 0: sampling window length in counted cycles; 0 disables windowing.
- SATURATE, 0: 1 = counters stick at all-ones; 0 = counters wrap to 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  enter RUN.
- stop  in  1  freeze counting (RUN -> HOLD).
- clear  in  1  zero live counters, overflow flags and window count.
- instr  in  PC_W  instruction currently in the fetch stage.
- pc  in  PC_W  current PC.
- ev  in  NUM_EV  generic event strobes, one count per high cycle.
- rsel  in  5  read select. Bit 4: 1 = shadow bank, 0 = live bank. Bits 3:0: counter index.
- rdata  out  CNT_W  registered read data.
- running  out  1  high in RUN.
- win_done  out  1  one-cycle pulse at window end.
- ovf  out  NUM_EV+4  sticky per-counter overflow flags, live bank.

Behaviour:
- Counter index map:
  - 0 cycles
  - 1 nops
  - 2 stalls
  - 3 instrs
  - 4+i ev[i]
  - Indices >= NUM_EV+4 read 0.
- Reset (rst low, async): state IDLE; all live/shadow counters, ovf, window count, rdata, win_done, running cleared to 0; prev_pc = 0, prev_valid = 0.
- FSM states: IDLE, RUN, HOLD.
  - IDLE -start-> RUN.
  - RUN -stop-> HOLD.
  - HOLD -start-> RUN.
  - stop and start asserted together: stop wins.
  - clear never changes state.
- Counting happens only in RUN, every clock:
  - cycles += 1.
  - nops += (instr == 0).
  - stalls += (prev_valid && pc == prev_pc).
  - instrs += (instr != 0 && !(prev_valid && pc == prev_pc)).
  - ev[i] counter += ev[i].
- prev_pc/prev_valid update only in RUN. Entering HOLD or IDLE clears prev_valid, so the first RUN cycle never counts a stall.
- Width and overflow:
  - An increment from all-ones sets the counter's ovf bit.
  - SATURATE=1: the counter holds at all-ones.
  - SATURATE=0: the counter wraps to 0.
- Window (WINDOW > 0):
  - win_cnt increments per RUN cycle.
  - On the RUN cycle where win_cnt == WINDOW-1:
    - Shadow bank <= live value including this cycle's increment.
    - Live counters and ovf <= 0.
    - win_cnt <= 0.
    - win_done = 1 on the next cycle, for one cycle.
  - HOLD pauses the window and does not reset it.
- clear priority:
  - clear beats counting and window end in the same cycle: no snapshot, no win_done, live counters = 0.
  - The shadow bank is untouched by clear; only reset zeroes it.
- Read: rdata <= selected counter one cycle after rsel is sampled. The value reflects registers before that edge's update.
- Reset mid-window or mid-RUN: immediate return to IDLE with all state zeroed; no win_done.

Decomposition:
- Package perf_monitor_pkg:
  - State enum {IDLE, RUN, HOLD}.
  - Index constants IDX_CYC=0, IDX_NOP=1, IDX_STALL=2, IDX_INSTR=3, IDX_EV0=4.
  - Read-bank bit position RSEL_SHADOW=4.
- Sub-module perf_counter, instantiated NUM_EV+4 times:
  - Inputs: inc, clr, load-zero, SATURATE.
  - Outputs: count and sticky ovf.
- Top holds the FSM, PC history, window logic, shadow bank and read mux.

Test Plan:
- Reset then start; drive 10 cycles with instr = nonzero, pc += 4 each cycle. Read idx 0/1/2/3 -> 10/0/0/10.
- In RUN, drive instr = 0 for 3 cycles with pc held constant after the first. Expect nops += 3, stalls += 2, instrs += 0.
- stop after 5 cycles, idle 20 cycles, start, run 5 more. cycles = 10; first cycle after resume does not count a stall.
- WINDOW = 8, run 8 cycles with ev[0] high on 3 of them. win_done pulses once on cycle 9; shadow idx 0 = 8, shadow idx 4 = 3; live idx 0 restarts from 0.
- CNT_W = 4, SATURATE = 1 vs 0, run 17 cycles. Cycles counter reads 15 vs 1 (wrapped); ovf[0] = 1 in both.
- clear asserted on the window-terminal cycle, plus async rst low mid-run. No win_done, shadow unchanged after clear; everything 0 and state IDLE after rst.

Source files
------------

// File: rtl/perf_monitor_pkg.sv
// rtl/perf_monitor_pkg.sv - shared state encoding and counter index map for perf_monitor
package perf_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int IDX_CYC     = 0;
    localparam int IDX_NOP     = 1;
    localparam int IDX_STALL   = 2;
    localparam int IDX_INSTR   = 3;
    localparam int IDX_EV0     = 4;
    localparam int RSEL_SHADOW = 4;

endpackage

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - single wrapping/saturating event counter with sticky overflow
module perf_counter #(
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             load_zero,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next,
    output logic             ovf
);

    logic at_max;
    assign at_max = &count;

    // count_next is exported so a snapshot can capture this cycle's increment
    always_comb begin
        count_next = count;
        if (inc && !(at_max && SATURATE)) begin
            count_next = count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr || load_zero) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            if (inc && at_max) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/perf_monitor.sv
// rtl/perf_monitor.sv - CPU cycle/instruction performance monitor with windowed shadow bank
module perf_monitor
    import perf_monitor_pkg::*;
#(
    parameter int NUM_EV   = 4,
    parameter int CNT_W    = 32,
    parameter int PC_W     = 32,
    parameter int WINDOW   = 0,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic [PC_W-1:0]   instr,
    input  logic [PC_W-1:0]   pc,
    input  logic [NUM_EV-1:0] ev,
    input  logic [4:0]        rsel,
    output logic [CNT_W-1:0]  rdata,
    output logic              running,
    output logic              win_done,
    output logic [NUM_EV+3:0] ovf
);

    localparam int NCNT  = NUM_EV + 4;
    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'((WINDOW > 0) ? WINDOW - 1 : 0);

    state_t state, state_nxt;
    logic [PC_W-1:0]  prev_pc;
    logic             prev_valid;
    logic             stall;
    logic             is_nop;
    logic [NCNT-1:0]  inc;
    logic [WIN_W-1:0] win_cnt;
    logic             win_end;
    logic [CNT_W-1:0] live     [NCNT];
    logic [CNT_W-1:0] live_nxt [NCNT];
    logic [CNT_W-1:0] shadow   [NCNT];
    logic [CNT_W-1:0] live_rd  [16];
    logic [CNT_W-1:0] shadow_rd[16];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // stop wins over start; clear never moves the FSM
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !stop) state_nxt = RUN;
            RUN:     if (stop)           state_nxt = HOLD;
            HOLD:    if (start && !stop) state_nxt = RUN;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        running = (state == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_pc    <= '0;
            prev_valid <= 1'b0;
        end else if (running) begin
            prev_pc    <= pc;
            prev_valid <= 1'b1;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    assign stall  = prev_valid && (pc == prev_pc);
    assign is_nop = (instr == '0);

    always_comb begin
        inc            = '0;
        inc[IDX_CYC]   = running;
        inc[IDX_NOP]   = running && is_nop;
        inc[IDX_STALL] = running && stall;
        inc[IDX_INSTR] = running && !is_nop && !stall;
        for (int i = 0; i < NUM_EV; i++) begin
            inc[IDX_EV0+i] = running && ev[i];
        end
    end

    assign win_end = (WINDOW > 0) && running && !clear && (win_cnt == WIN_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_cnt  <= '0;
            win_done <= 1'b0;
        end else begin
            win_done <= win_end;
            if (clear || win_end) begin
                win_cnt <= '0;
            end else if (running && (WINDOW > 0)) begin
                win_cnt <= win_cnt + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NCNT; k++) begin : g_cnt
        perf_counter #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE != 0)
        ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .inc        (inc[k]),
            .clr        (clear),
            .load_zero  (win_end),
            .count      (live[k]),
            .count_next (live_nxt[k]),
            .ovf        (ovf[k])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NCNT; k++) shadow[k] <= '0;
        end else if (win_end) begin
            for (int k = 0; k < NCNT; k++) shadow[k] <= live_nxt[k];
        end
    end

    // pad both banks to the full 16-entry select space so unmapped indices read 0
    for (genvar k = 0; k < 16; k++) begin : g_rd
        if (k < NCNT) begin : g_map
            assign live_rd[k]   = live[k];
            assign shadow_rd[k] = shadow[k];
        end else begin : g_zero
            assign live_rd[k]   = '0;
            assign shadow_rd[k] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else begin
            rdata <= rsel[RSEL_SHADOW] ? shadow_rd[rsel[3:0]] : live_rd[rsel[3:0]];
        end
    end

endmodule

// File: tb/tb_perf_monitor.sv
// tb/tb_perf_monitor.sv - directed self-checking bench for perf_monitor
module tb_perf_monitor;

    logic        clk = 1'b0;
    logic        rst, start, stop, clear;
    logic [31:0] instr, pc;
    logic [3:0]  ev;
    logic [4:0]  rsel;

    logic [31:0] rdata_m, rdata_w;
    logic [3:0]  rdata_s, rdata_r;
    logic        running_m, running_w, running_s, running_r;
    logic        win_done_m, win_done_w, win_done_s, win_done_r;
    logic [7:0]  ovf_m, ovf_w, ovf_s, ovf_r;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    perf_monitor #(.NUM_EV(4), .CNT_W(32), .PC_W(32), .WINDOW(0), .SATURATE(0)) u_main (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .instr(instr), .pc(pc),
        .ev(ev), .rsel(rsel), .rdata(rdata_m), .running(running_m), .win_done(win_done_m), .ovf(ovf_m));

    perf_monitor #(.NUM_EV(4), .CNT_W(32), .PC_W(32), .WINDOW(8), .SATURATE(0)) u_win (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .instr(instr), .pc(pc),
        .ev(ev), .rsel(rsel), .rdata(rdata_w), .running(running_w), .win_done(win_done_w), .ovf(ovf_w));

    perf_monitor #(.NUM_EV(4), .CNT_W(4), .PC_W(32), .WINDOW(0), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .instr(instr), .pc(pc),
        .ev(ev), .rsel(rsel), .rdata(rdata_s), .running(running_s), .win_done(win_done_s), .ovf(ovf_s));

    perf_monitor #(.NUM_EV(4), .CNT_W(4), .PC_W(32), .WINDOW(0), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .instr(instr), .pc(pc),
        .ev(ev), .rsel(rsel), .rdata(rdata_r), .running(running_r), .win_done(win_done_r), .ovf(ovf_r));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        instr = '0; pc = '0; ev = '0; rsel = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic step(input logic [31:0] i, input logic [31:0] p, input logic [3:0] e, input logic s);
        instr = i; pc = p; ev = e; stop = s;
        tick();
        stop = 1'b0; ev = '0;
    endtask

    task automatic sel(input logic [4:0] s);
        rsel = s;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (running_m !== 1'b0) begin bad++; $display("FAIL reset_running got %0b want 0", running_m); end
        total++; if (win_done_w !== 1'b0) begin bad++; $display("FAIL reset_win_done got %0b want 0", win_done_w); end
        total++; if (ovf_m !== 8'h00) begin bad++; $display("FAIL reset_ovf got %0h want 0", ovf_m); end
        total++; if (rdata_m !== 32'd0) begin bad++; $display("FAIL reset_rdata got %0d want 0", rdata_m); end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        total++; if (running_m !== 1'b0) begin bad++; $display("FAIL idle_stop_wins got %0b want 0", running_m); end
    endtask

    task automatic test_basic();
        do_reset();
        do_start();
        total++; if (running_m !== 1'b1) begin bad++; $display("FAIL basic_running got %0b want 1", running_m); end
        for (int i = 0; i < 10; i++) step(32'h13, 32'(4 * i), 4'hF, i == 9);
        total++; if (running_m !== 1'b0) begin bad++; $display("FAIL basic_hold got %0b want 0", running_m); end
        sel(5'd0); total++; if (rdata_m !== 32'd10) begin bad++; $display("FAIL basic_cycles got %0d want 10", rdata_m); end
        sel(5'd1); total++; if (rdata_m !== 32'd0)  begin bad++; $display("FAIL basic_nops got %0d want 0", rdata_m); end
        sel(5'd2); total++; if (rdata_m !== 32'd0)  begin bad++; $display("FAIL basic_stalls got %0d want 0", rdata_m); end
        sel(5'd3); total++; if (rdata_m !== 32'd10) begin bad++; $display("FAIL basic_instrs got %0d want 10", rdata_m); end
        sel(5'd4); total++; if (rdata_m !== 32'd10) begin bad++; $display("FAIL basic_ev0 got %0d want 10", rdata_m); end
        sel(5'd7); total++; if (rdata_m !== 32'd10) begin bad++; $display("FAIL basic_ev3 got %0d want 10", rdata_m); end
        sel(5'd8); total++; if (rdata_m !== 32'd0)  begin bad++; $display("FAIL basic_unmapped got %0d want 0", rdata_m); end
        sel(5'h10); total++; if (rdata_m !== 32'd0) begin bad++; $display("FAIL basic_shadow got %0d want 0", rdata_m); end
    endtask

    task automatic test_nop_stall();
        do_reset();
        do_start();
        step(32'h13, 32'd100, 4'h0, 1'b0);
        step(32'h13, 32'd104, 4'h0, 1'b0);
        step(32'h0,  32'd108, 4'h0, 1'b0);
        step(32'h0,  32'd108, 4'h0, 1'b0);
        step(32'h0,  32'd108, 4'h0, 1'b1);
        sel(5'd0); total++; if (rdata_m !== 32'd5) begin bad++; $display("FAIL ns_cycles got %0d want 5", rdata_m); end
        sel(5'd1); total++; if (rdata_m !== 32'd3) begin bad++; $display("FAIL ns_nops got %0d want 3", rdata_m); end
        sel(5'd2); total++; if (rdata_m !== 32'd2) begin bad++; $display("FAIL ns_stalls got %0d want 2", rdata_m); end
        sel(5'd3); total++; if (rdata_m !== 32'd2) begin bad++; $display("FAIL ns_instrs got %0d want 2", rdata_m); end
    endtask

    task automatic test_hold_resume();
        do_reset();
        do_start();
        for (int i = 0; i < 5; i++) step(32'h13, 32'(4 * i), 4'h0, i == 4);
        for (int i = 0; i < 20; i++) step(32'h13, 32'd16, 4'h0, 1'b0);
        total++; if (running_m !== 1'b0) begin bad++; $display("FAIL hr_hold got %0b want 0", running_m); end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        total++; if (running_m !== 1'b0) begin bad++; $display("FAIL hr_stop_wins got %0b want 0", running_m); end
        do_start();
        total++; if (running_m !== 1'b1) begin bad++; $display("FAIL hr_resume got %0b want 1", running_m); end
        for (int i = 0; i < 5; i++) step(32'h13, 32'(16 + 4 * i), 4'h0, i == 4);
        sel(5'd0); total++; if (rdata_m !== 32'd10) begin bad++; $display("FAIL hr_cycles got %0d want 10", rdata_m); end
        sel(5'd2); total++; if (rdata_m !== 32'd0)  begin bad++; $display("FAIL hr_stalls got %0d want 0", rdata_m); end
        sel(5'd3); total++; if (rdata_m !== 32'd10) begin bad++; $display("FAIL hr_instrs got %0d want 10", rdata_m); end
    endtask

    task automatic test_window();
        do_reset();
        do_start();
        for (int i = 0; i < 8; i++) begin
            step(32'h13, 32'(4 * i), (i == 0 || i == 3 || i == 6) ? 4'h1 : 4'h0, 1'b0);
            total++;
            if (win_done_w !== (i == 7)) begin
                bad++; $display("FAIL win_pulse_%0d got %0b want %0b", i, win_done_w, (i == 7));
            end
        end
        step(32'h13, 32'd32, 4'h0, 1'b1);
        total++; if (win_done_w !== 1'b0) begin bad++; $display("FAIL win_pulse_end got %0b want 0", win_done_w); end
        sel(5'h10); total++; if (rdata_w !== 32'd8) begin bad++; $display("FAIL win_shadow_cyc got %0d want 8", rdata_w); end
        sel(5'h14); total++; if (rdata_w !== 32'd3) begin bad++; $display("FAIL win_shadow_ev0 got %0d want 3", rdata_w); end
        sel(5'h13); total++; if (rdata_w !== 32'd8) begin bad++; $display("FAIL win_shadow_instr got %0d want 8", rdata_w); end
        sel(5'h00); total++; if (rdata_w !== 32'd1) begin bad++; $display("FAIL win_live_cyc got %0d want 1", rdata_w); end
        sel(5'h04); total++; if (rdata_w !== 32'd0) begin bad++; $display("FAIL win_live_ev0 got %0d want 0", rdata_w); end
    endtask

    task automatic test_width();
        do_reset();
        do_start();
        for (int i = 0; i < 17; i++) step(32'h13, 32'(4 * i), 4'h0, i == 16);
        sel(5'd0);
        total++; if (rdata_s !== 4'd15) begin bad++; $display("FAIL sat_cycles got %0d want 15", rdata_s); end
        total++; if (rdata_r !== 4'd1)  begin bad++; $display("FAIL wrap_cycles got %0d want 1", rdata_r); end
        sel(5'd3);
        total++; if (rdata_s !== 4'd15) begin bad++; $display("FAIL sat_instrs got %0d want 15", rdata_s); end
        total++; if (rdata_r !== 4'd1)  begin bad++; $display("FAIL wrap_instrs got %0d want 1", rdata_r); end
        total++; if (ovf_s !== 8'h09) begin bad++; $display("FAIL sat_ovf got %0h want 09", ovf_s); end
        total++; if (ovf_r !== 8'h09) begin bad++; $display("FAIL wrap_ovf got %0h want 09", ovf_r); end
        total++; if (ovf_m !== 8'h00) begin bad++; $display("FAIL wide_ovf got %0h want 00", ovf_m); end
    endtask

    task automatic test_clear_reset();
        do_reset();
        do_start();
        for (int i = 0; i < 8; i++) step(32'h13, 32'(4 * i), (i < 2) ? 4'h1 : 4'h0, 1'b0);
        for (int i = 0; i < 7; i++) step(32'h13, 32'(100 + 4 * i), 4'h1, 1'b0);
        clear = 1'b1;
        step(32'h13, 32'd200, 4'h1, 1'b0);
        clear = 1'b0;
        total++; if (win_done_w !== 1'b0) begin bad++; $display("FAIL clr_no_pulse got %0b want 0", win_done_w); end
        total++; if (running_w !== 1'b1)  begin bad++; $display("FAIL clr_keeps_run got %0b want 1", running_w); end
        step(32'h13, 32'd204, 4'h0, 1'b1);
        total++; if (win_done_w !== 1'b0) begin bad++; $display("FAIL clr_no_pulse2 got %0b want 0", win_done_w); end
        sel(5'h10); total++; if (rdata_w !== 32'd8) begin bad++; $display("FAIL clr_shadow_cyc got %0d want 8", rdata_w); end
        sel(5'h14); total++; if (rdata_w !== 32'd2) begin bad++; $display("FAIL clr_shadow_ev0 got %0d want 2", rdata_w); end
        sel(5'h00); total++; if (rdata_w !== 32'd1) begin bad++; $display("FAIL clr_live_cyc got %0d want 1", rdata_w); end
        do_start();
        for (int i = 0; i < 3; i++) step(32'h13, 32'(300 + 4 * i), 4'h0, 1'b0);
        sel(5'h10);
        total++; if (rdata_w !== 32'd8) begin bad++; $display("FAIL pre_rst_rdata got %0d want 8", rdata_w); end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        total++; if (running_w !== 1'b0) begin bad++; $display("FAIL rst_running got %0b want 0", running_w); end
        total++; if (rdata_w !== 32'd0)  begin bad++; $display("FAIL rst_rdata got %0d want 0", rdata_w); end
        total++; if (win_done_w !== 1'b0) begin bad++; $display("FAIL rst_win_done got %0b want 0", win_done_w); end
        tick();
        rst = 1'b1;
        tick();
        sel(5'h10); total++; if (rdata_w !== 32'd0) begin bad++; $display("FAIL rst_shadow got %0d want 0", rdata_w); end
        sel(5'h00); total++; if (rdata_w !== 32'd0) begin bad++; $display("FAIL rst_live got %0d want 0", rdata_w); end
        total++; if (running_w !== 1'b0) begin bad++; $display("FAIL rst_idle got %0b want 0", running_w); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nop_stall();
        test_hold_resume();
        test_window();
        test_width();
        test_clear_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
